// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch state encoding, defaults,
// PC step and the presented-instruction payload.
package fetch_pc_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP           = XLEN'(4);
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: async active-high reset to RESET_PC, load enable.
module fetch_pc_reg
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC and instruction-fetch stage: issues req/ack fetches, presents {pc, instr}
// to IF/ID, honours stalls and squashes fetches made stale by redirects.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr
);

  fetch_state_e    state, state_next;
  logic            pc_load;
  logic [XLEN-1:0] pc, pc_next, pc_plus4, target;
  logic [XLEN-1:0] addr_next, plus4_next;
  logic            req_next, valid_next;
  fetch_pkt_t      pkt, pkt_next;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .d     (pc_next),
    .q     (pc)
  );

  assign target   = word_align(redirect_pc);
  assign pc_plus4 = pc + PC_STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, PC update, request address and output latch. A request never
  // changes address before its ack, so a redirect without ack parks in DRAIN.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    pc_next    = pc;
    addr_next  = imem_addr;
    valid_next = if_valid;
    pkt_next   = pkt;
    plus4_next = if_pc_plus4;
    case (state)
      FETCH_IDLE: begin
        state_next = FETCH_REQ;
        addr_next  = pc;
      end
      FETCH_REQ: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          pc_next = target;
          if (imem_ack) begin
            addr_next = target;
          end else begin
            state_next = FETCH_DRAIN;
          end
        end else if (imem_ack) begin
          state_next     = FETCH_HOLD;
          valid_next     = 1'b1;
          pkt_next.pc    = pc;
          pkt_next.instr = imem_rdata;
          plus4_next     = pc_plus4;
        end
      end
      FETCH_DRAIN: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          pc_next = target;
        end
        // The stale request has completed; a same-cycle redirect is the newest target.
        if (imem_ack) begin
          state_next = FETCH_REQ;
          addr_next  = redirect_valid ? target : pc;
        end
      end
      FETCH_HOLD: begin
        if (redirect_valid) begin
          pc_load        = 1'b1;
          pc_next        = target;
          addr_next      = target;
          valid_next     = 1'b0;
          pkt_next.instr = NOP_INSTR;
          state_next     = FETCH_REQ;
        end else if (!stall) begin
          pc_load        = 1'b1;
          pc_next        = pc_plus4;
          addr_next      = pc_plus4;
          valid_next     = 1'b0;
          pkt_next.instr = NOP_INSTR;
          state_next     = FETCH_REQ;
        end
      end
      default: begin
        state_next = FETCH_IDLE;
      end
    endcase
    req_next = (state_next == FETCH_REQ) || (state_next == FETCH_DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      if_valid     <= 1'b0;
      pkt.pc       <= RESET_PC;
      pkt.instr    <= NOP_INSTR;
      if_pc_plus4  <= RESET_PC + PC_STEP;
    end else begin
      imem_req     <= req_next;
      imem_addr    <= addr_next;
      if_valid     <= valid_next;
      pkt          <= pkt_next;
      if_pc_plus4  <= plus4_next;
    end
  end

  assign if_pc    = pkt.pc;
  assign if_instr = pkt.instr;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized self-checking bench for fetch_pc_unit: two instances (default and
// wrap-around reset PC) compared every cycle against a transaction-level model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RPC [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  localparam logic [31:0] NOP [2] = '{32'h0000_0000, 32'hDEAD_0013};

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rdata;
  logic [1:0]  ack;
  logic [1:0]  req;
  logic [1:0]  valid;
  logic [31:0] addr  [2];
  logic [31:0] ifpc  [2];
  logic [31:0] plus4 [2];
  logic [31:0] instr [2];

  int n_checks = 0;
  int n_pass   = 0;

  // Model: "fetching" flag, whether the outstanding fetch is squashed, and
  // whether an instruction is currently presented.
  bit          started [2];
  bit          m_req   [2];
  bit          m_stale [2];
  bit          m_valid [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_ifpc  [2];
  logic [31:0] m_instr [2];

  bit          rnd = 1'b0;
  int          lat = 1;
  int          age [2];
  bit          prev_v [2];
  logic [31:0] dq0 [$];
  logic [31:0] dq1 [$];

  always #5 clk = ~clk;

  fetch_pc_unit u_dut0 (
    .clk (clk), .reset (reset), .stall (stall),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .imem_req (req[0]), .imem_addr (addr[0]), .imem_ack (ack[0]), .imem_rdata (rdata),
    .if_valid (valid[0]), .if_pc (ifpc[0]), .if_pc_plus4 (plus4[0]), .if_instr (instr[0])
  );

  fetch_pc_unit #(
    .RESET_PC (32'hFFFF_FFFC), .NOP_INSTR (32'hDEAD_0013)
  ) u_dut1 (
    .clk (clk), .reset (reset), .stall (stall),
    .redirect_valid (redirect_valid), .redirect_pc (redirect_pc),
    .imem_req (req[1]), .imem_addr (addr[1]), .imem_ack (ack[1]), .imem_rdata (rdata),
    .if_valid (valid[1]), .if_pc (ifpc[1]), .if_pc_plus4 (plus4[1]), .if_instr (instr[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      started[i] = 1'b0;  m_req[i] = 1'b0;  m_stale[i] = 1'b0;  m_valid[i] = 1'b0;
      m_pc[i] = RPC[i];   m_addr[i] = RPC[i]; m_ifpc[i] = RPC[i]; m_instr[i] = NOP[i];
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    tgt = {redirect_pc[31:2], 2'b00};
    for (int i = 0; i < 2; i++) begin
      if (!started[i]) begin
        started[i] = 1'b1;
        m_req[i]   = 1'b1;
        m_addr[i]  = m_pc[i];
      end else if (m_req[i]) begin
        if (redirect_valid) m_pc[i] = tgt;
        if (ack[i]) begin
          if (redirect_valid || m_stale[i]) begin
            m_stale[i] = 1'b0;
            m_addr[i]  = m_pc[i];
          end else begin
            m_req[i]   = 1'b0;
            m_valid[i] = 1'b1;
            m_instr[i] = rdata;
            m_ifpc[i]  = m_pc[i];
          end
        end else if (redirect_valid) begin
          m_stale[i] = 1'b1;
        end
      end else if (redirect_valid || !stall) begin
        m_pc[i]    = redirect_valid ? tgt : m_pc[i] + 32'd4;
        m_valid[i] = 1'b0;
        m_req[i]   = 1'b1;
        m_addr[i]  = m_pc[i];
      end
    end
  endtask

  task automatic check_outs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("i%0d_req", i),   32'(req[i]),   32'(m_req[i]));
      check($sformatf("i%0d_addr", i),  addr[i],       m_addr[i]);
      check($sformatf("i%0d_valid", i), 32'(valid[i]), 32'(m_valid[i]));
      check($sformatf("i%0d_pc", i),    ifpc[i],       m_ifpc[i]);
      check($sformatf("i%0d_pc4", i),   plus4[i],      m_ifpc[i] + 32'd4);
      check($sformatf("i%0d_instr", i), instr[i],      m_valid[i] ? m_instr[i] : NOP[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_step();
    #1;
    check_outs();
    if (valid[0] && !prev_v[0]) dq0.push_back(ifpc[0]);
    if (valid[1] && !prev_v[1]) dq1.push_back(ifpc[1]);
    prev_v[0] = valid[0];
    prev_v[1] = valid[1];
  endtask

  task automatic drive_acks();
    for (int i = 0; i < 2; i++) begin
      if (rnd) begin
        ack[i] = req[i] ? ($urandom_range(99) < 40) : ($urandom_range(99) < 5);
      end else begin
        if (!req[i]) age[i] = 0;
        ack[i] = req[i] && (age[i] >= lat);
        if (ack[i]) age[i] = 0;
        else if (req[i]) age[i]++;
      end
    end
    rdata = $urandom;
  endtask

  initial begin
    bit reached;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rdata = '0; ack = '0; age[0] = 0; age[1] = 0;
    prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    model_reset();
    #3;
    check_outs();
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch with one-cycle memory latency, then stall in HOLD at pc 8.
    lat = 1;
    reached = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (valid[0] && ifpc[0] == 32'h8) begin
        reached = 1'b1;
        break;
      end
      drive_acks();
      cycle();
    end
    check("t1_reach_pc8", 32'(reached), 32'd1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_acks();
      cycle();
      check("t2_stall_req", 32'(req[0]), 32'd0);
      check("t2_stall_pc", ifpc[0], 32'h8);
    end
    stall = 1'b0;
    drive_acks();
    cycle();
    check("t2_next_addr", addr[0], 32'hC);
    check("t1_deliveries", 32'(dq0.size()), 32'd3);
    check("t1_dq0", dq0[0] | dq0[1] << 8 | dq0[2] << 16, 32'h0008_0400);
    check("t5_wrap_first", dq1[0], 32'hFFFF_FFFC);
    check("t5_wrap_next", dq1[1], 32'h0);

    // Redirect while request pending: old address held, data discarded.
    lat = 2;
    drive_acks();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0403;
    cycle();
    redirect_valid = 1'b0;
    check("t3_drain_addr", addr[0], 32'hC);
    drive_acks();
    cycle();
    check("t3_drain_addr2", addr[0], 32'hC);
    drive_acks();
    cycle();
    check("t3_target_addr", addr[0], 32'h400);
    check("t3_no_valid", 32'(valid[0]), 32'd0);

    // Redirect coincident with ack, then redirect in HOLD during stall.
    lat = 1;
    drive_acks();
    cycle();
    drive_acks();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0800;
    cycle();
    redirect_valid = 1'b0;
    check("t4_no_valid", 32'(valid[0]), 32'd0);
    check("t4_target_addr", addr[0], 32'h800);
    drive_acks();
    cycle();
    drive_acks();
    cycle();
    check("t4_hold_pc", ifpc[0], 32'h800);
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    drive_acks();
    cycle();
    redirect_valid = 1'b0; stall = 1'b0;
    check("t4_hold_redir_valid", 32'(valid[0]), 32'd0);
    check("t4_hold_redir_addr", addr[0], 32'h1000);

    // Reset asserted while draining, with a stale ack after release.
    lat = 3;
    drive_acks();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    cycle();
    redirect_valid = 1'b0;
    check("t6_drain_addr", addr[0], 32'h1000);
    reset = 1'b1;
    #1;
    model_reset();
    check_outs();
    check("t6_reset_req", 32'(req[0]), 32'd0);
    ack = 2'b11;
    cycle();
    @(negedge clk);
    reset = 1'b0;
    cycle();
    check("t6_restart_addr", addr[1], 32'hFFFF_FFFC);

    // Random traffic with occasional asynchronous resets.
    rnd = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      stall          = ($urandom_range(99) < 30);
      redirect_valid = ($urandom_range(99) < 10);
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : 32'($urandom);
      drive_acks();
      if ($urandom_range(399) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
